enid_mem_target: RTL and testbench

ENID_MEM_TARGET -- requirements
Module: enid_mem_target

---
 rtl/enid_mem_target.sv | 194 +++++++++++++++++++
 tb/tb_enid_mem_target.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enid_mem_target.sv
`default_nettype none
// ============================================================================
// Module      : enid_mem_target
// Description : enid memory target; single-port block RAM behind a header/beat
//               handshake. Define ENID_MEM_TARGET_DEST_CHECK_EN to answer only
//               to MY_MOD/MY_SUB (status 11 otherwise).
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef ENID_MODULE_ID_W
`define ENID_MODULE_ID_W 4
`endif
`ifndef ENID_SUB_ID_W
`define ENID_SUB_ID_W 2
`endif
`ifndef ENID_ADDR_W
`define ENID_ADDR_W 32
`endif
`ifndef ENID_LEN_W
`define ENID_LEN_W 8
`endif

module enid_mem_target #(
   parameter int                           MEM_DEPTH = 1024,
   parameter logic [`ENID_MODULE_ID_W-1:0] MY_MOD    = 4'd1,
   parameter logic [`ENID_SUB_ID_W-1:0]    MY_SUB    = 2'd0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic [1:0]                   req_type,
   input  logic [1:0]                   req_mem_op,
   input  logic [`ENID_MODULE_ID_W-1:0] req_dest_mod,
   input  logic [`ENID_SUB_ID_W-1:0]    req_dest_sub,
   input  logic [`ENID_ADDR_W-1:0]      req_addr,
   input  logic [`ENID_LEN_W-1:0]       req_len,
   input  logic                         req_wvalid,
   output logic                         req_wready,
   input  logic [31:0]                  req_wdata,
   input  logic                         req_wlast,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic [1:0]                   rsp_status,
   output logic [`ENID_LEN_W-1:0]       rsp_len,
   output logic                         rsp_rvalid,
   input  logic                         rsp_rready,
   output logic [31:0]                  rsp_rdata,
   output logic                         rsp_rlast
);

   localparam int c_aw  = $clog2(MEM_DEPTH);
   localparam int c_adw = `ENID_ADDR_W;
   localparam int c_lw  = `ENID_LEN_W;
   localparam logic [c_adw:0]  c_depth   = (c_adw+1)'(MEM_DEPTH);
   localparam logic [c_lw-1:0] c_len_one = c_lw'(1);
   localparam logic [c_aw-1:0] c_ptr_one = c_aw'(1);

   localparam logic [2:0] c_st_idle  = 3'd0;
   localparam logic [2:0] c_st_wdata = 3'd1;
   localparam logic [2:0] c_st_wrsp  = 3'd2;
   localparam logic [2:0] c_st_rhdr  = 3'd3;
   localparam logic [2:0] c_st_rdata = 3'd4;

   localparam logic [1:0] c_ok        = 2'b00;
   localparam logic [1:0] c_addr_err  = 2'b01;
   localparam logic [1:0] c_proto_err = 2'b10;
   localparam logic [1:0] c_no_tgt    = 2'b11;

   logic [2:0]      r_state;
   logic [1:0]      r_status;
   logic [c_lw-1:0] r_len;
   logic [c_lw-1:0] r_cnt;
   logic [c_aw-1:0] r_ptr;
   logic [31:0]     r_mem [MEM_DEPTH];
   logic [31:0]     r_mem_q;

   logic            w_last;
   logic            w_wbeat;
   logic            w_wlast_bad;
   logic            w_rhdr_hs;
   logic            w_rbeat;
   logic            w_we;
   logic            w_re;
   logic [1:0]      w_hdr_status;
   logic [c_adw:0]  w_end_word;

   // Later assignments win, giving the 11 > 01 > 10 priority.
   always_comb begin
      w_end_word   = {3'b000, req_addr[c_adw-1:2]} + (c_adw+1)'(req_len);
      w_hdr_status = c_ok;
      if (req_len == '0 || req_type != 2'b00 || req_mem_op[1])
         w_hdr_status = c_proto_err;
      if (req_addr[1:0] != 2'b00 || w_end_word > c_depth)
         w_hdr_status = c_addr_err;
`ifdef ENID_MEM_TARGET_DEST_CHECK_EN
      if (req_dest_mod != MY_MOD || req_dest_sub != MY_SUB)
         w_hdr_status = c_no_tgt;
`endif
   end

`ifndef ENID_MEM_TARGET_DEST_CHECK_EN
   logic w_unused;
   assign w_unused = ^{req_dest_mod, req_dest_sub, MY_MOD, MY_SUB, c_no_tgt};
`endif

   assign w_last      = (r_cnt == r_len - c_len_one);
   assign w_wbeat     = (r_state == c_st_wdata) && req_wvalid && !rst;
   assign w_wlast_bad = (req_wlast != w_last);
   assign w_rhdr_hs   = (r_state == c_st_rhdr) && rsp_ready && !rst;
   assign w_rbeat     = (r_state == c_st_rdata) && rsp_rready && !rst;
   assign w_we        = w_wbeat && (r_status == c_ok) && !w_wlast_bad;
   // Prefetch the next word on each handshake so rdata only moves on a beat.
   assign w_re        = (w_rhdr_hs && (r_status == c_ok)) || (w_rbeat && !w_last);

   always_ff @(posedge clk) begin
      if (w_we)
         r_mem[r_ptr] <= req_wdata;
      else if (w_re)
         r_mem_q <= r_mem[r_ptr];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= c_st_idle;
         r_status <= c_ok;
         r_len    <= '0;
         r_cnt    <= '0;
         r_ptr    <= '0;
      end else begin
         case (r_state)
            c_st_idle: begin
               if (req_valid) begin
                  r_status <= w_hdr_status;
                  r_len    <= req_len;
                  r_cnt    <= '0;
                  r_ptr    <= req_addr[c_aw+1:2];
                  if (req_mem_op == 2'b01)
                     r_state <= (req_len == '0) ? c_st_wrsp : c_st_wdata;
                  else
                     r_state <= c_st_rhdr;
               end
            end
            c_st_wdata: begin
               if (req_wvalid) begin
                  if (w_wlast_bad && r_status == c_ok)
                     r_status <= c_proto_err;
                  r_ptr <= r_ptr + c_ptr_one;
                  r_cnt <= r_cnt + c_len_one;
                  if (w_last)
                     r_state <= c_st_wrsp;
               end
            end
            c_st_wrsp: begin
               if (rsp_ready)
                  r_state <= c_st_idle;
            end
            c_st_rhdr: begin
               if (rsp_ready) begin
                  if (r_status == c_ok) begin
                     r_state <= c_st_rdata;
                     r_ptr   <= r_ptr + c_ptr_one;
                  end else begin
                     r_state <= c_st_idle;
                  end
               end
            end
            c_st_rdata: begin
               if (rsp_rready) begin
                  if (w_last) begin
                     r_state <= c_st_idle;
                  end else begin
                     r_cnt <= r_cnt + c_len_one;
                     r_ptr <= r_ptr + c_ptr_one;
                  end
               end
            end
            default: r_state <= c_st_idle;
         endcase
      end
   end

   assign req_ready  = (r_state == c_st_idle) && !rst;
   assign req_wready = (r_state == c_st_wdata) && !rst;
   assign rsp_valid  = ((r_state == c_st_wrsp) || (r_state == c_st_rhdr)) && !rst;
   assign rsp_status = rsp_valid ? r_status : 2'b00;
   assign rsp_len    = (rsp_valid && ((r_state == c_st_wrsp) || (r_status == c_ok))) ? r_len : '0;
   assign rsp_rvalid = (r_state == c_st_rdata) && !rst;
   assign rsp_rdata  = rsp_rvalid ? r_mem_q : 32'd0;
   assign rsp_rlast  = rsp_rvalid && w_last;

endmodule

`default_nettype wire

// File: tb/tb_enid_mem_target.sv
`default_nettype none
// ============================================================================
// Module      : tb_enid_mem_target
// Description : self-checking bench for enid_mem_target (table, directed and
//               randomized transactions against a word-array reference model).
// Revision    : 1.0 - initial release
// ============================================================================

module tb_enid_mem_target;

   localparam int DEPTH = 1024;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready;
   logic [1:0]  req_type, req_mem_op;
   logic [3:0]  req_dest_mod;
   logic [1:0]  req_dest_sub;
   logic [31:0] req_addr;
   logic [7:0]  req_len;
   logic        req_wvalid, req_wready;
   logic [31:0] req_wdata;
   logic        req_wlast;
   logic        rsp_valid, rsp_ready;
   logic [1:0]  rsp_status;
   logic [7:0]  rsp_len;
   logic        rsp_rvalid, rsp_rready;
   logic [31:0] rsp_rdata;
   logic        rsp_rlast;

   always #5 clk = ~clk;

   enid_mem_target #(.MEM_DEPTH(DEPTH), .MY_MOD(4'd1), .MY_SUB(2'd0)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_type(req_type), .req_mem_op(req_mem_op),
      .req_dest_mod(req_dest_mod), .req_dest_sub(req_dest_sub),
      .req_addr(req_addr), .req_len(req_len),
      .req_wvalid(req_wvalid), .req_wready(req_wready),
      .req_wdata(req_wdata), .req_wlast(req_wlast),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_status(rsp_status), .rsp_len(rsp_len),
      .rsp_rvalid(rsp_rvalid), .rsp_rready(rsp_rready),
      .rsp_rdata(rsp_rdata), .rsp_rlast(rsp_rlast)
   );

   int          errors = 0;
   int          checks = 0;
   logic [31:0] model_mem [DEPTH];
   logic [31:0] rd_q [$];
   logic        rl_q [$];

   typedef struct {
      logic [1:0]  op;
      logic [1:0]  typ;
      logic [31:0] addr;
      logic [7:0]  len;
      logic [1:0]  exp_st;
      logic [7:0]  exp_len;
   } vec_t;

   vec_t vecs [13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: no handshake within the cycle budget", name);
   endtask

   // Status derived straight from the address/length/type rules.
   function automatic logic [1:0] model_status(input logic [1:0] typ, input logic [1:0] op,
                                               input logic [31:0] addr, input logic [7:0] len);
`ifdef ENID_MEM_TARGET_DEST_CHECK_EN
      if (req_dest_mod != 4'd1 || req_dest_sub != 2'd0) return 2'b11;
`endif
      if ((addr % 4) != 0 || (longint'(addr) / 4 + longint'(len)) > DEPTH) return 2'b01;
      if (len == 8'd0 || typ != 2'b00 || op > 2'b01) return 2'b10;
      return 2'b00;
   endfunction

   task automatic send_hdr(input logic [1:0] op, input logic [1:0] typ,
                           input logic [31:0] addr, input logic [7:0] len);
      int n = 0;
      @(negedge clk);
      req_mem_op = op; req_type = typ; req_addr = addr; req_len = len; req_valid = 1'b1;
      while (!req_ready && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) timeout("hdr_handshake");
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic get_rsp(output logic [1:0] st, output logic [7:0] ln);
      int n = 0;
      @(negedge clk);
      rsp_ready = 1'b1;
      while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) timeout("rsp_handshake");
      st = rsp_status;
      ln = rsp_len;
      check("rsp_excl", 32'(rsp_rvalid), 32'd0);
      @(posedge clk); #1;
      rsp_ready = 1'b0;
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] typ,
                           input int bad_beat, input logic [31:0] first, input bit rnd,
                           output logic [1:0] st, output logic [7:0] ln, output logic [1:0] exp_st);
      logic [31:0] d;
      logic [1:0]  s;
      int          n;
      int          accepted = 0;
      s = model_status(typ, 2'b01, addr, len);
      send_hdr(2'b01, typ, addr, len);
      for (int i = 0; i < int'(len); i++) begin
         d = rnd ? $urandom : first + 32'(i);
         if (rnd && $urandom_range(3) == 0) @(negedge clk);
         @(negedge clk);
         req_wvalid = 1'b1;
         req_wdata  = d;
         req_wlast  = (i == int'(len) - 1) ^ (i == bad_beat);
         n = 0;
         while (!req_wready && n < 50) begin @(negedge clk); n++; end
         if (n >= 50) begin timeout("wbeat_handshake"); req_wvalid = 1'b0; break; end
         @(posedge clk); #1;
         req_wvalid = 1'b0;
         accepted++;
         if (i == bad_beat && s == 2'b00) s = 2'b10;
         if (s == 2'b00) model_mem[addr / 4 + 32'(i)] = d;
      end
      check("wr_beats_accepted", 32'(accepted), 32'(len));
      @(negedge clk);
      check("wr_wready_off", 32'(req_wready), 32'd0);
      get_rsp(st, ln);
      exp_st = s;
   endtask

   // mode: 0 always ready, 1 ready pattern 1,0,0,1 repeating, 2 random
   task automatic do_read(input logic [1:0] op, input logic [1:0] typ, input logic [31:0] addr,
                          input logic [7:0] len, input int mode,
                          output logic [1:0] st, output logic [7:0] ln, output logic [1:0] exp_st);
      int          n = 0;
      int          ph = 0;
      bit          first = 1'b1;
      bit          rdy;
      logic        stall = 1'b0;
      logic [31:0] held_d = '0;
      logic        held_l = 1'b0;
      exp_st = model_status(typ, op, addr, len);
      rd_q.delete();
      rl_q.delete();
      send_hdr(op, typ, addr, len);
      get_rsp(st, ln);
      if (st != 2'b00) begin
         @(negedge clk);
         check("rd_hdr_only", 32'(rsp_rvalid), 32'd0);
         return;
      end
      while (rd_q.size() < int'(len) && n < 400) begin
         @(negedge clk);
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = (ph % 4 == 0) || (ph % 4 == 3);
            default: rdy = 1'($urandom_range(1));
         endcase
         ph++;
         rsp_rready = rdy;
         if (first) begin check("rd_first_latency", 32'(rsp_rvalid), 32'd1); first = 1'b0; end
         check("rd_excl", 32'(rsp_valid & rsp_rvalid), 32'd0);
         if (stall) begin
            check("rd_hold_data", rsp_rdata, held_d);
            check("rd_hold_last", 32'(rsp_rlast), 32'(held_l));
         end
         stall  = rsp_rvalid && !rdy;
         held_d = rsp_rdata;
         held_l = rsp_rlast;
         if (rsp_rvalid && rdy) begin rd_q.push_back(rsp_rdata); rl_q.push_back(rsp_rlast); end
         n++;
      end
      if (n >= 400) timeout("rd_beats");
      @(posedge clk); #1;
      rsp_rready = 1'b0;
      @(negedge clk);
      check("rd_end_idle", 32'(rsp_rvalid), 32'd0);
      for (int i = 0; i < rd_q.size(); i++) begin
         check("rd_data", rd_q[i], model_mem[addr / 4 + 32'(i)]);
         check("rd_last", 32'(rl_q[i]), 32'(i == int'(len) - 1));
      end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [1:0]  st, es;
      logic [7:0]  ln;
      logic [31:0] saved, addr;
      logic [7:0]  len;
      logic [1:0]  typ;
      int          bad;

      vecs[0]  = '{2'b01, 2'b00, 32'h0000_0200, 8'd2, 2'b00, 8'd2};
      vecs[1]  = '{2'b00, 2'b00, 32'h0000_0200, 8'd2, 2'b00, 8'd2};
      vecs[2]  = '{2'b00, 2'b00, 32'h0000_0011, 8'd1, 2'b01, 8'd0};
      vecs[3]  = '{2'b00, 2'b00, 32'h0000_0000, 8'd0, 2'b10, 8'd0};
      vecs[4]  = '{2'b00, 2'b01, 32'h0000_0000, 8'd1, 2'b10, 8'd0};
      vecs[5]  = '{2'b10, 2'b00, 32'h0000_0000, 8'd1, 2'b10, 8'd0};
      vecs[6]  = '{2'b00, 2'b00, 32'h0000_0FFC, 8'd1, 2'b00, 8'd1};
      vecs[7]  = '{2'b00, 2'b00, 32'h0000_0FFC, 8'd2, 2'b01, 8'd0};
      vecs[8]  = '{2'b00, 2'b00, 32'h0000_0FFD, 8'd0, 2'b01, 8'd0};
      vecs[9]  = '{2'b01, 2'b00, 32'h0000_0FFC, 8'd2, 2'b01, 8'd2};
      vecs[10] = '{2'b01, 2'b00, 32'h0000_0300, 8'd0, 2'b10, 8'd0};
      vecs[11] = '{2'b01, 2'b10, 32'h0000_0300, 8'd2, 2'b10, 8'd2};
      vecs[12] = '{2'b00, 2'b00, 32'h0000_1000, 8'd1, 2'b01, 8'd0};

      rst = 1'b1;
      req_valid = 1'b0; req_type = 2'b00; req_mem_op = 2'b00;
      req_dest_mod = 4'd1; req_dest_sub = 2'd0; req_addr = '0; req_len = '0;
      req_wvalid = 1'b0; req_wdata = '0; req_wlast = 1'b0;
      rsp_ready = 1'b0; rsp_rready = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_wready", 32'(req_wready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rvalid", 32'(rsp_rvalid), 32'd0);
      check("rst_rdata", rsp_rdata, 32'd0);
      check("rst_rsp_len", 32'(rsp_len), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_rst", 32'(req_ready), 32'd1);

      for (int k = 0; k < DEPTH / 128; k++) begin
         do_write(32'(k * 512), 8'd128, 2'b00, -1, 32'd0, 1'b1, st, ln, es);
         check("fill_status", 32'(st), 32'd0);
      end

      do_write(32'h10, 8'd4, 2'b00, -1, 32'd1, 1'b0, st, ln, es);
      check("wr4_status", 32'(st), 32'd0);
      check("wr4_len", 32'(ln), 32'd4);
      do_read(2'b00, 2'b00, 32'h10, 8'd4, 0, st, ln, es);
      check("rd4_status", 32'(st), 32'd0);
      check("rd4_len", 32'(ln), 32'd4);
      check("rd4_beats", 32'(rd_q.size()), 32'd4);
      for (int i = 0; i < rd_q.size(); i++) begin
         check("rd4_value", rd_q[i], 32'(i + 1));
         check("rd4_rlast", 32'(rl_q[i]), 32'(i == 3));
      end

      do_read(2'b00, 2'b00, 32'h100, 8'd8, 1, st, ln, es);
      check("rd8_stall_len", 32'(ln), 32'd8);
      check("rd8_stall_beats", 32'(rd_q.size()), 32'd8);

      // Reset in the middle of a read burst.
      send_hdr(2'b00, 2'b00, 32'h10, 8'd4);
      get_rsp(st, ln);
      @(negedge clk);
      rsp_rready = 1'b1;
      check("rstmid_beat1", rsp_rdata, 32'd1);
      @(negedge clk);
      check("rstmid_beat2", rsp_rdata, 32'd2);
      rst = 1'b1;
      @(negedge clk);
      check("rstmid_req_ready", 32'(req_ready), 32'd0);
      check("rstmid_rvalid", 32'(rsp_rvalid), 32'd0);
      check("rstmid_rdata", rsp_rdata, 32'd0);
      check("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("rstmid_ready_after", 32'(req_ready), 32'd1);
      check("rstmid_no_beats", 32'(rsp_rvalid), 32'd0);
      @(negedge clk);
      check("rstmid_no_beats2", 32'(rsp_rvalid | rsp_valid), 32'd0);
      rsp_rready = 1'b0;
      do_read(2'b00, 2'b00, 32'h10, 8'd1, 0, st, ln, es);
      check("rstmid_reread", (rd_q.size() > 0) ? rd_q[0] : 32'hDEAD_BEEF, 32'd1);

      saved = model_mem[1023];
      do_write(32'hFFC, 8'd2, 2'b00, -1, 32'd0, 1'b1, st, ln, es);
      check("wr_oob_status", 32'(st), 32'd1);
      check("wr_oob_len", 32'(ln), 32'd2);
      do_read(2'b00, 2'b00, 32'hFFC, 8'd1, 0, st, ln, es);
      check("wr_oob_kept", (rd_q.size() > 0) ? rd_q[0] : ~saved, saved);

      do_write(32'h20, 8'd3, 2'b00, 1, 32'hA0, 1'b0, st, ln, es);
      check("wr_badlast_status", 32'(st), 32'd2);
      check("wr_badlast_len", 32'(ln), 32'd3);
      do_read(2'b00, 2'b00, 32'h20, 8'd3, 0, st, ln, es);
      check("wr_badlast_beat1_kept", (rd_q.size() > 0) ? rd_q[0] : 32'h0, 32'hA0);
      do_read(2'b00, 2'b00, 32'h0, 8'd0, 0, st, ln, es);
      check("rd_len0_status", 32'(st), 32'd2);
      check("rd_len0_len", 32'(ln), 32'd0);
      check("rd_len0_beats", 32'(rd_q.size()), 32'd0);

      for (int v = 0; v < 13; v++) begin
         if (vecs[v].op == 2'b01)
            do_write(vecs[v].addr, vecs[v].len, vecs[v].typ, -1, 32'd0, 1'b1, st, ln, es);
         else
            do_read(vecs[v].op, vecs[v].typ, vecs[v].addr, vecs[v].len, 0, st, ln, es);
         check($sformatf("vec%0d_status", v), 32'(st), 32'(vecs[v].exp_st));
         check($sformatf("vec%0d_len", v), 32'(ln), 32'(vecs[v].exp_len));
      end

`ifdef ENID_MEM_TARGET_DEST_CHECK_EN
      saved = model_mem[16];
      req_dest_mod = 4'd2;
      do_write(32'h40, 8'd2, 2'b00, -1, 32'd0, 1'b1, st, ln, es);
      check("dest_status", 32'(st), 32'd3);
      do_read(2'b00, 2'b00, 32'h40, 8'd1, 0, st, ln, es);
      check("dest_rd_status", 32'(st), 32'd3);
      check("dest_rd_beats", 32'(rd_q.size()), 32'd0);
      req_dest_mod = 4'd1;
      do_read(2'b00, 2'b00, 32'h40, 8'd1, 0, st, ln, es);
      check("dest_mem_kept", (rd_q.size() > 0) ? rd_q[0] : ~saved, saved);
`endif

      for (int t = 0; t < 60; t++) begin
         addr = 32'($urandom_range(0, DEPTH - 1)) * 4;
         if ($urandom_range(9) == 0) addr = addr + 32'($urandom_range(1, 3));
         len = 8'($urandom_range(1, 16));
         if ($urandom_range(19) == 0) len = 8'd0;
         typ = ($urandom_range(15) == 0) ? 2'b01 : 2'b00;
         if ($urandom_range(1) == 1) begin
            bad = (len != 0 && $urandom_range(5) == 0) ? int'($urandom_range(0, int'(len) - 1)) : -1;
            do_write(addr, len, typ, bad, 32'd0, 1'b1, st, ln, es);
            check("rnd_wr_status", 32'(st), 32'(es));
            check("rnd_wr_len", 32'(ln), 32'(len));
         end else begin
            do_read(($urandom_range(15) == 0) ? 2'b11 : 2'b00, typ, addr, len, 2, st, ln, es);
            check("rnd_rd_status", 32'(st), 32'(es));
            check("rnd_rd_len", 32'(ln), (es == 2'b00) ? 32'(len) : 32'd0);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
